// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the multicycle RISC-V control path
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - maps alu_op plus funct fields to the ALU operation code
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op_b5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Subtract only for R-type funct3=000 with bit 30 set; I-type addi has op[5]=0.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op_b5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_control_fsm.sv
// rtl/riscv_control_fsm.sv - multicycle RISC-V Moore control FSM; JAL support under RISCV_CTRL_JAL_EN
module riscv_control_fsm
  import riscv_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic [STATE_W-1:0] state
);

`ifdef RISCV_CTRL_JAL_EN
  localparam logic JAL_EN = 1'b1;
`else
  localparam logic JAL_EN = 1'b0;
`endif

  state_t  state_q, state_d, cur;
  alu_op_t alu_op;
  logic    pc_update, branch;
  logic    mem_write_raw, ir_write_raw, reg_write_raw;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state: decode dispatches on opcode, unknown opcodes fall back to fetch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = JAL_EN ? S_JAL : S_FETCH;
          OP_BRANCH:         state_d = S_BEQ;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs; during reset the fetch decode is presented with enables masked below.
  always_comb begin
    cur           = rst ? S_FETCH : state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    case (cur)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_update    = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write  = ~rst & (pc_update | (branch & zero));
  assign mem_write = ~rst & mem_write_raw;
  assign ir_write  = ~rst & ir_write_raw;
  assign reg_write = ~rst & reg_write_raw;
  assign state     = STATE_W'(state_q);

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = JAL_EN ? IMM_J : IMM_I;
      default:   imm_src = IMM_I;
    endcase
  end

  riscv_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op_b5_i       (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control)
  );

endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb/tb_riscv_control_fsm.sv - self-checking bench for riscv_control_fsm
module tb_riscv_control_fsm;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;
  int  rst_left = 0;
  iq_t m_seq;

  always #5 clk = ~clk;

  riscv_control_fsm #(.STATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .state       (state)
  );

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Full list of states an instruction visits, starting at fetch.
  function automatic iq_t seq_for(input logic [6:0] o);
    iq_t q;
    q.push_back(0);
    q.push_back(1);
    case (o)
      7'b0000011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      7'b0100011: begin q.push_back(2); q.push_back(5); end
      7'b0110011: begin q.push_back(6); q.push_back(7); end
      7'b0010011: begin q.push_back(8); q.push_back(7); end
      7'b1100011: q.push_back(10);
`ifdef RISCV_CTRL_JAL_EN
      7'b1101111: begin q.push_back(9); q.push_back(7); end
`endif
      default: ;
    endcase
    return q;
  endfunction

  function automatic int m_cur();
    return (m_seq.size() != 0) ? m_seq[0] : 0;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
`ifdef RISCV_CTRL_JAL_EN
    if (o == 7'b1101111) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_alu(input int s, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (s == 10) return 3'b001;
    if (s == 6 || s == 8) begin
      if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
    end
    return 3'b000;
  endfunction

  // Model advance: each instruction walks its fixed state list; reset discards it.
  always @(posedge clk) begin
    if (rst) m_seq.delete();
    else begin
      if (m_seq.size() == 0) m_seq = seq_for(op);
      void'(m_seq.pop_front());
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int s;
    int d;
    bit en;
    if (chk_en) begin
      s  = m_cur();
      d  = rst ? 0 : s;
      en = !rst;
      cmp("state", state, s);
      cmp("pc_write", pc_write, en && (d == 0 || d == 9 || (d == 10 && zero)));
      cmp("adr_src", adr_src, (d == 3 || d == 5));
      cmp("mem_write", mem_write, en && d == 5);
      cmp("ir_write", ir_write, en && d == 0);
      cmp("reg_write", reg_write, en && (d == 4 || d == 7));
      cmp("result_src", result_src, (d == 0) ? 2 : (d == 4) ? 1 : 0);
      cmp("alu_src_a", alu_src_a, (d == 1 || d == 9) ? 1 : (d == 2 || d == 6 || d == 8 || d == 10) ? 2 : 0);
      cmp("alu_src_b", alu_src_b, (d == 0 || d == 9) ? 2 : (d == 1 || d == 2 || d == 8) ? 1 : 0);
      cmp("imm_src", imm_src, exp_imm(op));
      cmp("alu_control", alu_control, exp_alu(d, op, funct3, funct7b5));
    end
  end

  // Directed instruction with a literal state list packed one nibble per cycle.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int n,
                           input logic [47:0] sp, input logic [2:0] alu_lit);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      logic [3:0] es;
      es = sp[4*i +: 4];
      if (i > 0) begin @(posedge clk); #2; end
      cmp({name, "_state"}, state, es);
      cmp({name, "_reg_write"}, reg_write, (es == 4 || es == 7));
      cmp({name, "_mem_write"}, mem_write, (es == 5));
      if (es == 1) cmp({name, "_pc_write_dec"}, pc_write, 0);
      if (es == 4) cmp({name, "_result_src"}, result_src, 1);
      if (es == 6 || es == 8 || es == 10) cmp({name, "_alu_control"}, alu_control, alu_lit);
      if (es == 10) begin
        cmp({name, "_pc_write_beq"}, pc_write, z);
        cmp({name, "_imm_src"}, imm_src, 2);
      end
      if (es == 9) cmp({name, "_pc_write_jal"}, pc_write, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      cmp("rst_state", state, 0);
      cmp("rst_pc_write", pc_write, 0);
      cmp("rst_ir_write", ir_write, 0);
      cmp("rst_mem_write", mem_write, 0);
      cmp("rst_reg_write", reg_write, 0);
    end
    rst = 1'b0;
    #1;
    cmp("release_ir_write", ir_write, 1);
    cmp("release_state", state, 0);

    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 6, 48'h043210, 3'b000);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 5, 48'h05210,  3'b000);
    run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 5, 48'h07610,  3'b001);
    run_instr("slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 5, 48'h07610,  3'b101);
    run_instr("addi",    7'b0010011, 3'b000, 1'b1, 1'b0, 5, 48'h07810,  3'b000);
    run_instr("beq_tk",  7'b1100011, 3'b000, 1'b0, 1'b1, 4, 48'h0A10,   3'b001);
    run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 4, 48'h0A10,   3'b001);
`ifdef RISCV_CTRL_JAL_EN
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 5, 48'h07910,  3'b000);
`else
    run_instr("jal_off", 7'b1101111, 3'b000, 1'b0, 1'b0, 3, 48'h010,    3'b000);
`endif
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 3, 48'h010,    3'b000);

    for (int c = 0; c < 4000; c++) begin
      int k;
      @(posedge clk); #1;
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 99) == 0) rst_left = $urandom_range(1, 2);
      end
      zero = 1'($urandom_range(0, 1));
      if (m_cur() == 0) begin
        k = $urandom_range(0, 7);
        case (k)
          0: op = 7'b0000011;
          1: op = 7'b0100011;
          2: op = 7'b0110011;
          3: op = 7'b0010011;
          4: op = 7'b1101111;
          5: op = 7'b1100011;
          default: op = 7'($urandom_range(0, 127));
        endcase
        funct3   = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
      end
    end

    rst = 1'b0;
    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
